// File: rtl/alu_word_seq.sv
// Sequences one wide operation through a shared BUS_WIDTH-bit combinational ALU,
// one slice per clock from the LSB slice, optionally chaining carry between slices.
module alu_word_seq #(
    parameter int unsigned BUS_WIDTH    = 8,
    parameter int unsigned PREFIX_WIDTH = 2,
    parameter int unsigned INST_WIDTH   = 3,
    parameter int unsigned NUM_WORDS    = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [PREFIX_WIDTH+INST_WIDTH-1:0]  req_opcode,
    input  logic [BUS_WIDTH*NUM_WORDS-1:0]      req_a,
    input  logic [BUS_WIDTH*NUM_WORDS-1:0]      req_b,
    input  logic                                req_cin,
    input  logic                                req_chain,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [BUS_WIDTH*NUM_WORDS-1:0]      rsp_y,
    output logic                                rsp_cout,
    output logic [PREFIX_WIDTH+INST_WIDTH-1:0]  alu_opcode,
    output logic [BUS_WIDTH-1:0]                alu_a,
    output logic [BUS_WIDTH-1:0]                alu_b,
    output logic                                alu_cin,
    input  logic [BUS_WIDTH-1:0]                alu_y,
    input  logic                                alu_cout
);

    localparam int unsigned OP_WIDTH  = PREFIX_WIDTH + INST_WIDTH;
    localparam int unsigned W         = BUS_WIDTH * NUM_WORDS;
    localparam int unsigned IDX_WIDTH = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [OP_WIDTH-1:0]    op_q, op_d;
    logic [W-1:0]           a_q, a_d;
    logic [W-1:0]           b_q, b_d;
    logic                   cin_q, cin_d;
    logic                   chain_q, chain_d;
    logic [W-1:0]           result_q, result_d;
    logic                   carry_q, carry_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            chain_q  <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            chain_q  <= chain_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        chain_d  = chain_q;
        result_d = result_q;
        carry_d  = carry_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d     = req_opcode;
                    a_d      = req_a;
                    b_d      = req_b;
                    cin_d    = req_cin;
                    chain_d  = req_chain;
                    result_d = '0;
                    idx_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                result_d[idx_q*BUS_WIDTH +: BUS_WIDTH] = alu_y;
                carry_d = alu_cout;
                if (idx_q == LAST_IDX) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ALU inputs are only live during RUN so the shared ALU sees zeros otherwise.
    always_comb begin
        alu_opcode = '0;
        alu_a      = '0;
        alu_b      = '0;
        alu_cin    = 1'b0;
        if (state_q == StRun) begin
            alu_opcode = op_q;
            alu_a      = a_q[idx_q*BUS_WIDTH +: BUS_WIDTH];
            alu_b      = b_q[idx_q*BUS_WIDTH +: BUS_WIDTH];
            alu_cin    = (idx_q == '0 || !chain_q) ? cin_q : carry_q;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StDone);
    assign rsp_y     = result_q;
    assign rsp_cout  = carry_q;

endmodule

// File: tb/tb_alu_word_seq.sv
// Directed bench for alu_word_seq with a two-opcode ALU model (add-with-carry, XOR).
module tb_alu_word_seq;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [4:0]    req_opcode;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;
    logic          req_cin;
    logic          req_chain;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_y;
    logic          rsp_cout;
    logic [4:0]    alu_opcode;
    logic [7:0]    alu_a;
    logic [7:0]    alu_b;
    logic          alu_cin;
    logic [7:0]    alu_y;
    logic          alu_cout;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    alu_word_seq #(
        .BUS_WIDTH    (8),
        .PREFIX_WIDTH (2),
        .INST_WIDTH   (3),
        .NUM_WORDS    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .req_chain  (req_chain),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_y      (rsp_y),
        .rsp_cout   (rsp_cout),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cin    (alu_cin),
        .alu_y      (alu_y),
        .alu_cout   (alu_cout)
    );

    always_comb begin
        alu_y    = 8'h00;
        alu_cout = 1'b0;
        case (alu_opcode)
            5'b00000: {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
            5'b00001: alu_y = alu_a ^ alu_b;
            default: ;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic chain);
        req_opcode = op;
        req_a      = a;
        req_b      = b;
        req_cin    = cin;
        req_chain  = chain;
    endtask

    // Issues one request from IDLE, waits (bounded) for the response and completes it.
    // lat is the number of cycles from acceptance to rsp_valid, or -1 on timeout.
    task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic chain,
                          output logic [W-1:0] y, output logic cout, output int lat);
        set_req(op, a, b, cin, chain);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        y    = rsp_y;
        cout = rsp_cout;
        if (rsp_valid) begin
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end else begin
            lat = -1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            $display("FAIL reset_hs: ready=%b valid=%b required ready=1 valid=0",
                     req_ready, rsp_valid);
            tests_failed++;
        end
        tests_run++;
        if (rsp_y !== 32'h0 || rsp_cout !== 1'b0) begin
            $display("FAIL reset_rsp: y=%h cout=%b required y=0 cout=0", rsp_y, rsp_cout);
            tests_failed++;
        end
        tests_run++;
        if (alu_opcode !== 5'h0 || alu_a !== 8'h0 || alu_b !== 8'h0 || alu_cin !== 1'b0) begin
            $display("FAIL reset_alu: op=%h a=%h b=%h cin=%b required all 0",
                     alu_opcode, alu_a, alu_b, alu_cin);
            tests_failed++;
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add_chain_carry();
        int k;
        set_req(5'b00000, 32'h000000FF, 32'h00000001, 1'b0, 1'b1);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tests_run++;
        if (alu_a !== 8'hFF || alu_b !== 8'h01 || alu_cin !== 1'b0) begin
            $display("FAIL slice0_alu: a=%h b=%h cin=%b required a=ff b=01 cin=0",
                     alu_a, alu_b, alu_cin);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (alu_a !== 8'h00 || alu_cin !== 1'b1) begin
            $display("FAIL slice1_alu: a=%h cin=%b required a=00 cin=1", alu_a, alu_cin);
            tests_failed++;
        end
        // Edge T+1 is behind us; rsp_valid must appear only after edge T+4.
        for (k = 2; k <= 4; k++) begin
            tick();
            tests_run++;
            if (rsp_valid !== (k == 4)) begin
                $display("FAIL latency_c%0d: rsp_valid=%b required %b", k, rsp_valid, k == 4);
                tests_failed++;
            end
        end
        tests_run++;
        if (rsp_y !== 32'h00000100 || rsp_cout !== 1'b0) begin
            $display("FAIL add_ff_1: y=%h cout=%b required y=00000100 cout=0",
                     rsp_y, rsp_cout);
            tests_failed++;
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            $display("FAIL post_hs: valid=%b ready=%b required valid=0 ready=1",
                     rsp_valid, req_ready);
            tests_failed++;
        end
    endtask

    task automatic test_add_chain();
        logic [W-1:0] y;
        logic         c;
        int           lat;
        run_op(5'b00000, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, y, c, lat);
        tests_run++;
        if (lat != 4 || y !== 32'h00000000 || c !== 1'b1) begin
            $display("FAIL add_wrap: y=%h cout=%b lat=%0d required y=00000000 cout=1 lat=4",
                     y, c, lat);
            tests_failed++;
        end
        run_op(5'b00000, 32'h12345678, 32'h11111111, 1'b1, 1'b1, y, c, lat);
        tests_run++;
        if (lat != 4 || y !== 32'h2345678A || c !== 1'b0) begin
            $display("FAIL add_cin: y=%h cout=%b lat=%0d required y=2345678a cout=0 lat=4",
                     y, c, lat);
            tests_failed++;
        end
    endtask

    task automatic test_unchained();
        logic [W-1:0] y;
        logic         c;
        int           lat;
        run_op(5'b00000, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, y, c, lat);
        tests_run++;
        if (lat != 4 || y !== 32'hFFFFFF00 || c !== 1'b0) begin
            $display("FAIL add_nochain: y=%h cout=%b lat=%0d required y=ffffff00 cout=0 lat=4",
                     y, c, lat);
            tests_failed++;
        end
        run_op(5'b00001, 32'hA5A5A5A5, 32'hFFFF0000, 1'b0, 1'b0, y, c, lat);
        tests_run++;
        if (lat != 4 || y !== 32'h5A5AA5A5 || c !== 1'b0) begin
            $display("FAIL xor: y=%h cout=%b lat=%0d required y=5a5aa5a5 cout=0 lat=4",
                     y, c, lat);
            tests_failed++;
        end
    endtask

    task automatic test_backpressure();
        int n;
        set_req(5'b00000, 32'h00000003, 32'h00000004, 1'b0, 1'b1);
        req_valid = 1'b1;
        tick();
        // Second request stays pending for the whole first transaction.
        set_req(5'b00000, 32'h00000010, 32'h00000020, 1'b0, 1'b1);
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_y !== 32'h00000007 || rsp_cout !== 1'b0 ||
                req_ready !== 1'b0) begin
                $display("FAIL bp_hold_c%0d: valid=%b y=%h cout=%b ready=%b required 1 00000007 0 0",
                         k, rsp_valid, rsp_y, rsp_cout, req_ready);
                tests_failed++;
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tests_run++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            $display("FAIL bp_after_hs: ready=%b valid=%b required ready=1 valid=0",
                     req_ready, rsp_valid);
            tests_failed++;
        end
        tick();
        req_valid = 1'b0;
        tests_run++;
        if (req_ready !== 1'b0 || alu_a !== 8'h10) begin
            $display("FAIL bp_second_accept: ready=%b alu_a=%h required ready=0 alu_a=10",
                     req_ready, alu_a);
            tests_failed++;
        end
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        tests_run++;
        if (n != 4 || rsp_y !== 32'h00000030) begin
            $display("FAIL bp_second_rsp: y=%h lat=%0d required y=00000030 lat=4", rsp_y, n);
            tests_failed++;
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] y;
        logic         c;
        int           lat;
        int           seen;
        set_req(5'b00001, 32'h5555AAAA, 32'h0F0F0F0F, 1'b1, 1'b1);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            $display("FAIL mid_reset_hs: ready=%b valid=%b required ready=1 valid=0",
                     req_ready, rsp_valid);
            tests_failed++;
        end
        tests_run++;
        if (alu_opcode !== 5'h0 || alu_a !== 8'h0 || alu_b !== 8'h0 || alu_cin !== 1'b0) begin
            $display("FAIL mid_reset_alu: op=%h a=%h b=%h cin=%b required all 0",
                     alu_opcode, alu_a, alu_b, alu_cin);
            tests_failed++;
        end
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (rsp_valid === 1'b1) seen++;
            tick();
        end
        tests_run++;
        if (seen != 0) begin
            $display("FAIL mid_reset_norsp: rsp_valid cycles=%0d required 0", seen);
            tests_failed++;
        end
        run_op(5'b00000, 32'h00000001, 32'h00000001, 1'b0, 1'b1, y, c, lat);
        tests_run++;
        if (lat != 4 || y !== 32'h00000002 || c !== 1'b0) begin
            $display("FAIL post_reset_add: y=%h cout=%b lat=%0d required y=00000002 cout=0 lat=4",
                     y, c, lat);
            tests_failed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]   ops [3];
        logic [W-1:0] as  [3];
        logic [W-1:0] bs  [3];
        logic [W-1:0] exp [3];
        logic [W-1:0] got_y [3];
        int           acc_cyc [3];
        int           cyc;
        int           k;
        int           got;
        logic         acc;
        logic         hs;
        ops[0] = 5'b00000; as[0] = 32'h00000010; bs[0] = 32'h00000020; exp[0] = 32'h00000030;
        ops[1] = 5'b00001; as[1] = 32'hF0F0F0F0; bs[1] = 32'h0F0F0F0F; exp[1] = 32'hFFFFFFFF;
        ops[2] = 5'b00000; as[2] = 32'h7FFFFFFF; bs[2] = 32'h00000001; exp[2] = 32'h80000000;
        for (int i = 0; i < 3; i++) begin
            acc_cyc[i] = -100;
            got_y[i]   = 'x;
        end
        cyc = 0;
        k   = 0;
        got = 0;
        set_req(ops[0], as[0], bs[0], 1'b0, 1'b1);
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        while (got < 3 && cyc < 60) begin
            acc = req_valid && req_ready;
            hs  = rsp_valid && rsp_ready;
            if (hs) got_y[got] = rsp_y;
            tick();
            cyc++;
            if (acc) begin
                acc_cyc[k] = cyc;
                k++;
                if (k < 3) set_req(ops[k], as[k], bs[k], 1'b0, 1'b1);
                else req_valid = 1'b0;
            end
            if (hs) got++;
        end
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (got_y[i] !== exp[i]) begin
                $display("FAIL b2b_rsp%0d: y=%h required %h", i, got_y[i], exp[i]);
                tests_failed++;
            end
        end
        for (int i = 1; i < 3; i++) begin
            tests_run++;
            if (acc_cyc[i] - acc_cyc[i-1] != 6) begin
                $display("FAIL b2b_interval%0d: interval=%0d required 6",
                         i, acc_cyc[i] - acc_cyc[i-1]);
                tests_failed++;
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        set_req(5'b0, '0, '0, 1'b0, 1'b0);
        test_reset();
        test_add_chain_carry();
        test_add_chain();
        test_unchained();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_word_seq.md
# alu_word_seq

Multi-slice sequencer that runs one wide operation through the shared 8-bit combinational ALU (`op_decode`), one BUS_WIDTH slice per clock, LSB slice first. It optionally chains the ALU carry-out of each slice into the carry-in of the next. It sits between an instruction-issue stage (request side, valid/ready) and a writeback stage (response side, valid/ready). It is the only driver of the ALU's opcode/A/B/Cin inputs.

## Interface
- BUS_WIDTH, 8, ALU slice width
- PREFIX_WIDTH, 2, opcode prefix bits
- INST_WIDTH, 3, opcode instruction bits
- NUM_WORDS, 4, slices per wide operation (≥1); wide width W = BUS_WIDTH*NUM_WORDS
- clk  in  1  system clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_opcode  in  PREFIX_WIDTH+INST_WIDTH  ALU opcode for every slice
- req_a, req_b  in  W  wide operands
- req_cin  in  1  carry-in for slice 0 (every slice when unchained)
- req_chain  in  1  1 = propagate slice Cout to next slice Cin
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_y  out  W  wide result
- rsp_cout  out  1  ALU Cout of the final (MSB) slice
- alu_opcode  out  PREFIX_WIDTH+INST_WIDTH  to ALU opcode
- alu_a, alu_b  out  BUS_WIDTH  to ALU A/B
- alu_cin  out  1  to ALU Cin
- alu_y  in  BUS_WIDTH  from ALU Y
- alu_cout  in  1  from ALU Cout

## Operation
- States: IDLE, RUN, DONE. Slice index `idx` has width max(1, clog2(NUM_WORDS)).
- IDLE: req_ready=1. On req_valid&&req_ready, latch opcode/a/b/cin/chain, clear result register, set idx=0, and go to RUN.
- RUN: req_ready=0. ALU outputs are combinational from the latched request and idx:
  - alu_opcode = latched opcode.
  - alu_a/alu_b = slice idx of the latched operands (bits idx*BUS_WIDTH +: BUS_WIDTH).
  - alu_cin = latched cin if idx==0 or chain==0; otherwise carry_reg.
- Each RUN clock writes alu_y into result slice idx and sets carry_reg<=alu_cout.
  - If idx==NUM_WORDS-1, go to DONE. Otherwise idx++.
- DONE: rsp_valid=1. rsp_y and rsp_cout (=carry_reg) are held stable. On rsp_valid&&rsp_ready, go to IDLE.
- No request overlap: req_ready stays 0 in RUN and DONE.
- Outside RUN, alu_opcode/alu_a/alu_b/alu_cin are driven to 0.
- Unchained mode: each slice is independent, but rsp_cout still reports the MSB slice's Cout.
- Reset values: state=IDLE, req_ready=1 (after the reset edge), rsp_valid=0, rsp_y=0, rsp_cout=0, alu_* = 0, idx=0, carry_reg=0.
- Reset mid-operation (RUN or DONE): abort, discard partial result, no response issued, back to IDLE on that edge.
- rst has priority over any handshake in the same cycle.

## Timing
- Request accepted at edge T. RUN occupies cycles T..T+NUM_WORDS-1.
- rsp_valid rises after edge T+NUM_WORDS (latency NUM_WORDS cycles).
- The earliest next acceptance is one cycle after the response handshake. Minimum initiation interval is NUM_WORDS+2 cycles with rsp_ready held high.
- NUM_WORDS=1: a single RUN cycle, and rsp_valid rises after edge T+1.
- The ALU is purely combinational. The path alu_* -> ALU -> alu_y/alu_cout -> result/carry registers must close in one cycle.
- rsp_y and rsp_cout do not change while rsp_valid=1 and rsp_ready=0.

## Test plan
The bench uses an ALU model with two opcodes:
- 5'b00000 = add-with-carry: {Cout,Y} = A+B+Cin.
- 5'b00001 = XOR: Cout=0.

All scenarios use NUM_WORDS=4.

1. Add, chain=1, A=0x000000FF, B=0x00000001, cin=0 -> rsp_y=0x00000100, rsp_cout=0. rsp_valid is high exactly 4 cycles after acceptance. alu_cin=1 on slice 1.
2. Add, chain=1, A=0xFFFFFFFF, B=0x00000001, cin=0 -> rsp_y=0x00000000, rsp_cout=1. Add, chain=1, A=0x12345678, B=0x11111111, cin=1 -> rsp_y=0x2345678A, rsp_cout=0.
3. Add, chain=0, A=0xFFFFFFFF, B=0x00000001, cin=0 -> rsp_y=0xFFFFFF00, rsp_cout=0. XOR, A=0xA5A5A5A5, B=0xFFFF0000 -> rsp_y=0x5A5AA5A5, rsp_cout=0.
4. Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid while a second req_valid is held high -> rsp_y/rsp_cout stay stable and req_ready=0 throughout. The second request is accepted exactly one cycle after the response handshake.
5. Reset: assert rst for one cycle after 2 RUN slices -> next cycle state=IDLE, req_ready=1, rsp_valid=0, alu_* = 0, and no response for the aborted request. A following add 0x00000001+0x00000001 returns 0x00000002.
6. Back-to-back traffic with rsp_ready=1: 3 consecutive requests complete in order, accepted at intervals of 6 cycles.
